dnn_accuracy_monitor: RTL and testbench
=======================================

# dnn_accuracy_monitor

Output-side scoreboard for the DNN training loop. It consumes the network's per-block-cycle output `actL_alln` together with the ideal one-hot label of each training case. It realigns each label with the network's pipeline latency, grades every case as correct or incorrect, and accumulates windowed and total accuracy counts. It sits next to `DNN_top`, alongside the ideal-output memory, and is the reader end of the stream that the training-case feed logic writes.

## Interface
Parameters:
- `NOUT`, 10: label width; number of meaningful output neurons.
- `N_OUT`, 64: number of output neurons, n[L-1]; must be ≥ `NOUT`.
- `DELAY`, 2: number of block cycles between a label entering and the matching `actL_alln` being valid; must be ≥ 1.
- `WINDOW`, 1000: number of graded cases per accuracy window; must be ≥ 1.
- `CW`, $clog2(WINDOW+1): width of the window counters (derived).

Ports:
- `clk`, in, 1: system clock.
- `reset`, in, 1: synchronous, active-high; one clock, `clk`.
- `cycle_clk`, in, 1: block-cycle clock from the DNN; sampled as data in the `clk` domain.
- `ans_tc`, in, `NOUT`: one-hot ideal label of the case issued in the current block cycle.
- `actL_alln`, in, `N_OUT`: 1-bit network outputs for all output neurons.
- `case_valid`, out, 1: one-clock pulse when a case has been graded.
- `case_correct`, out, 1: grade of the last graded case; held until the next grade.
- `win_correct`, out, `CW`: correct count in the current window.
- `win_cases`, out, `CW`: graded count in the current window.
- `window_done`, out, 1: one-clock pulse at window completion.
- `last_window_correct`, out, `CW`: correct count of the most recently completed window.
- `total_cases`, out, 32: graded cases since reset; saturates at 2^32-1.

## Operation
- **Boundary detect:** register `cc_d <= cycle_clk`; `boundary = cycle_clk & ~cc_d`. On reset `cc_d` is set to 1, so a `cycle_clk` that is already high does not produce a spurious boundary.
- **Label delay line:** `DELAY` entries, each holding {valid, label}.
  - Each boundary shifts `ans_tc` in with valid=1 and shifts the oldest entry out.
  - Reset clears every valid bit.
- **Grading:** on a boundary, the entry being shifted out is graded only if its valid bit is 1.
  - `correct = (actL_alln[NOUT-1:0] == label)`, an exact bitwise match.
  - Neurons `NOUT..N_OUT-1` are ignored.
  - An all-zero label is never treated specially.
- **Warm-up:** the first `DELAY` boundaries after reset produce no grade and do not change any counter.
- **Counters, on a graded case:**
  - `win_cases` increments by 1, and `win_correct` increments by `correct`.
  - `total_cases` increments and saturates.
- **Window completion:** when the increment makes `win_cases` reach `WINDOW`, in the same update:
  - `last_window_correct` is loaded with the new correct count (including this case);
  - `window_done` pulses;
  - `win_cases` and `win_correct` are set to 0.
- **Reset outputs:** all outputs are 0 after reset, including `last_window_correct` and `case_correct`.
- **Reset mid-operation:** reset discards the partial window and the delay-line contents. Reset has priority over a simultaneous boundary.
- **Consecutive boundaries:** back-to-back boundaries (every other `clk`) must each be graded; there is no throughput limit beyond boundary detection.

## Timing
- A boundary is detected combinationally in clk cycle t, from `cycle_clk` and `cc_d`.
- Grading state updates at the end of cycle t and is visible in cycle t+1:
  - `case_valid`, `case_correct`, the counters, `window_done` and `last_window_correct`.
- `case_valid` and `window_done` are high for exactly one `clk` cycle.
- `actL_alln` and `ans_tc` are sampled in cycle t, the boundary cycle. Both must be stable at that point; `DNN_top` guarantees this because both change only on `cycle_clk`.
- Latency from a label entering to its grade: `DELAY` boundaries, plus 1 `clk`.
- Non-boundary cycles hold all state; pulse outputs are 0.

## Test plan
- **Warm-up:** reset, `DELAY`=2, then 3 boundaries with labels 0x001, 0x002, 0x004 and `actL_alln[9:0]`=0x001 at the third.
  - Expect no `case_valid` at boundaries 1–2.
  - At boundary 3, `case_valid`=1, `case_correct`=1, `win_correct`=1, `win_cases`=1.
- **Mismatch and ignored neurons:** label 0x008 with `actL_alln[9:0]`=0x018 → incorrect. Label 0x008 with `actL_alln`=0x008 plus bit 40 set → correct.
- **Window wrap:** `WINDOW`=4, grade correct, incorrect, correct, correct.
  - Expect `window_done` after the 4th grade, `last_window_correct`=3, and `win_cases`/`win_correct`=0 in the same cycle.
  - The 5th grade gives `win_cases`=1.
- **Reset mid-window:** after 2 graded cases, assert reset for 1 clk.
  - All counters and `last_window_correct` read 0.
  - The next `DELAY` boundaries are ungraded.
- **Edge detect:** hold `cycle_clk` high across reset release → no boundary. Toggle `cycle_clk` every `clk` (boundary every 2 clks) → every boundary graded, `total_cases` increments by 1 per boundary.

Source files
------------

// File: rtl/dnn_accuracy_monitor.sv
`default_nettype none
// ============================================================================
// Module   : dnn_accuracy_monitor
// Purpose  : Output-side scoreboard for the DNN training loop. Delays each
//            one-hot training label by the network pipeline latency, grades
//            the network output against it on every block-cycle boundary and
//            accumulates windowed and total accuracy counts.
// Ports    : clk, reset             - system clock, sync active-high reset
//            cycle_clk             - DNN block-cycle clock (sampled as data)
//            ans_tc                - ideal one-hot label of the current case
//            actL_alln             - 1-bit outputs of all output neurons
//            case_valid            - one-clock pulse per graded case
//            case_correct          - grade of the last graded case (held)
//            win_correct/win_cases - running counts of the current window
//            window_done           - one-clock pulse on window completion
//            last_window_correct   - correct count of the last full window
//            total_cases           - graded cases since reset (saturating)
// Revision : 1.0 - initial release
// ============================================================================
module dnn_accuracy_monitor #(
  parameter int NOUT   = 10,
  parameter int N_OUT  = 64,
  parameter int DELAY  = 2,
  parameter int WINDOW = 1000,
  parameter int CW     = $clog2(WINDOW + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cycle_clk,
  input  logic [NOUT-1:0]  ans_tc,
  input  logic [N_OUT-1:0] actL_alln,
  output logic             case_valid,
  output logic             case_correct,
  output logic [CW-1:0]    win_correct,
  output logic [CW-1:0]    win_cases,
  output logic             window_done,
  output logic [CW-1:0]    last_window_correct,
  output logic [31:0]      total_cases
);

  localparam logic [CW-1:0] C_WINDOW = CW'(WINDOW);

  // Previous cycle_clk sample; reset to 1 so a cycle_clk already high at
  // reset release is not mistaken for a rising edge.
  logic            r_cc_d;
  // Label delay line: index 0 is the newest entry, DELAY-1 the oldest.
  logic [DELAY-1:0] r_vld;
  logic [NOUT-1:0]  r_lbl [DELAY];

  logic            w_boundary;
  logic            w_grade;
  logic            w_correct;
  logic [CW-1:0]   w_win_cases_inc;
  logic [CW-1:0]   w_win_correct_inc;
  logic            w_wrap;

  assign w_boundary        = cycle_clk & ~r_cc_d;
  assign w_grade           = w_boundary & r_vld[DELAY-1];
  // Exact match on the meaningful neurons only; an all-zero label is graded
  // like any other.
  assign w_correct         = (actL_alln[NOUT-1:0] == r_lbl[DELAY-1]);
  assign w_win_cases_inc   = win_cases + 1'b1;
  assign w_win_correct_inc = win_correct + CW'(w_correct);
  assign w_wrap            = (w_win_cases_inc == C_WINDOW);

  // Neurons above NOUT never affect the grade.
  generate
    if (N_OUT > NOUT) begin : g_unused_hi
      logic w_unused_hi;
      assign w_unused_hi = ^actL_alln[N_OUT-1:NOUT];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cc_d              <= 1'b1;
      r_vld               <= '0;
      case_valid          <= 1'b0;
      case_correct        <= 1'b0;
      win_correct         <= '0;
      win_cases           <= '0;
      window_done         <= 1'b0;
      last_window_correct <= '0;
      total_cases         <= '0;
    end else begin
      r_cc_d      <= cycle_clk;
      case_valid  <= 1'b0;
      window_done <= 1'b0;
      if (w_boundary) begin
        r_lbl[0] <= ans_tc;
        r_vld[0] <= 1'b1;
        for (int i = 1; i < DELAY; i++) begin
          r_lbl[i] <= r_lbl[i-1];
          r_vld[i] <= r_vld[i-1];
        end
        if (w_grade) begin
          case_valid   <= 1'b1;
          case_correct <= w_correct;
          if (total_cases != '1) begin
            total_cases <= total_cases + 32'd1;
          end
          if (w_wrap) begin
            last_window_correct <= w_win_correct_inc;
            window_done         <= 1'b1;
            win_cases           <= '0;
            win_correct         <= '0;
          end else begin
            win_cases   <= w_win_cases_inc;
            win_correct <= w_win_correct_inc;
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dnn_accuracy_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_dnn_accuracy_monitor
// Purpose  : Self-checking bench for dnn_accuracy_monitor (DELAY=2,
//            WINDOW=4). A queue-based reference model grades each case from
//            the label issued DELAY boundaries earlier; directed sequences
//            cover warm-up, mismatch, ignored neurons, window wrap, reset
//            mid-window and edge detection, followed by random traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dnn_accuracy_monitor;

  localparam int NOUT   = 10;
  localparam int N_OUT  = 64;
  localparam int DELAY  = 2;
  localparam int WINDOW = 4;
  localparam int CW     = $clog2(WINDOW + 1);

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             cycle_clk = 1'b0;
  logic [NOUT-1:0]  ans_tc = '0;
  logic [N_OUT-1:0] actL_alln = '0;
  logic             case_valid;
  logic             case_correct;
  logic [CW-1:0]    win_correct;
  logic [CW-1:0]    win_cases;
  logic             window_done;
  logic [CW-1:0]    last_window_correct;
  logic [31:0]      total_cases;

  dnn_accuracy_monitor #(
    .NOUT(NOUT), .N_OUT(N_OUT), .DELAY(DELAY), .WINDOW(WINDOW)
  ) dut (
    .clk(clk), .reset(reset), .cycle_clk(cycle_clk), .ans_tc(ans_tc),
    .actL_alln(actL_alln), .case_valid(case_valid),
    .case_correct(case_correct), .win_correct(win_correct),
    .win_cases(win_cases), .window_done(window_done),
    .last_window_correct(last_window_correct), .total_cases(total_cases)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  logic [NOUT-1:0] m_q[$];
  bit      m_ccd = 1'b1;
  bit      m_valid, m_correct, m_wdone;
  int      m_wcases, m_wcorrect, m_last;
  longint  m_total;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic model_clear();
    m_q.delete();
    m_ccd = 1'b1;
    m_valid = 0; m_correct = 0; m_wdone = 0;
    m_wcases = 0; m_wcorrect = 0; m_last = 0; m_total = 0;
  endtask

  // Apply the rules to the inputs present before the coming edge.
  task automatic model_step();
    bit b, c;
    logic [NOUT-1:0] lbl;
    if (reset) begin
      model_clear();
      return;
    end
    b = cycle_clk && !m_ccd;
    m_ccd = cycle_clk;
    m_valid = 0;
    m_wdone = 0;
    if (b) begin
      m_q.push_back(ans_tc);
      if (m_q.size() > DELAY) begin
        lbl = m_q.pop_front();
        c = (actL_alln[NOUT-1:0] == lbl);
        m_valid = 1;
        m_correct = c;
        if (m_total < 64'hFFFF_FFFF) m_total++;
        m_wcases++;
        m_wcorrect += int'(c);
        if (m_wcases == WINDOW) begin
          m_last = m_wcorrect;
          m_wcases = 0;
          m_wcorrect = 0;
          m_wdone = 1;
        end
      end
    end
  endtask

  // One clk: update model, pass the edge, compare every output.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("case_valid",   64'(case_valid),          64'(m_valid));
    check("case_correct", 64'(case_correct),        64'(m_correct));
    check("win_correct",  64'(win_correct),         64'(m_wcorrect));
    check("win_cases",    64'(win_cases),           64'(m_wcases));
    check("window_done",  64'(window_done),         64'(m_wdone));
    check("last_win",     64'(last_window_correct), 64'(m_last));
    check("total_cases",  64'(total_cases),         64'(m_total));
  endtask

  // One block cycle: a low clk then a rising boundary carrying the inputs.
  task automatic bnd(input logic [NOUT-1:0] lbl, input logic [N_OUT-1:0] act);
    cycle_clk = 1'b0;
    tick();
    cycle_clk = 1'b1;
    ans_tc = lbl;
    actL_alln = act;
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int t0;
    logic [NOUT-1:0] lbl;
    logic [N_OUT-1:0] act;

    // Reset state
    do_reset();
    check("rst_total", 64'(total_cases), 64'd0);

    // Warm-up: first DELAY boundaries are not graded
    bnd(10'h001, 64'h0);
    check("warm1_valid", 64'(case_valid), 64'd0);
    bnd(10'h002, 64'h0);
    check("warm2_valid", 64'(case_valid), 64'd0);
    bnd(10'h004, 64'h001);
    check("b3_valid",   64'(case_valid),   64'd1);
    check("b3_correct", 64'(case_correct), 64'd1);
    check("b3_wcor",    64'(win_correct),  64'd1);
    check("b3_wcases",  64'(win_cases),    64'd1);

    // Grade 2 correct, grade 3 mismatch (label 4 vs 0x018)
    bnd(10'h008, 64'h002);
    bnd(10'h008, 64'h018);
    check("mis_correct", 64'(case_correct), 64'd0);
    // Grade 4: label 8 with a high ignored neuron set -> correct, wraps window
    bnd(10'h010, 64'h008 | (64'd1 << 40));
    check("hi_correct",  64'(case_correct),        64'd1);
    check("wrap_done",   64'(window_done),         64'd1);
    check("wrap_last",   64'(last_window_correct), 64'd3);
    check("wrap_wcases", 64'(win_cases),           64'd0);
    check("wrap_wcor",   64'(win_correct),         64'd0);
    tick();
    check("done_pulse", 64'(window_done), 64'd0);
    // Grade 5: label 8 vs 0x018 -> incorrect, first of a new window
    bnd(10'h020, 64'h018);
    check("g5_wcases",  64'(win_cases),    64'd1);
    check("g5_correct", 64'(case_correct), 64'd0);
    bnd(10'h040, 64'h010);
    check("g6_wcases", 64'(win_cases), 64'd2);

    // Reset mid-window with cycle_clk held high across release
    cycle_clk = 1'b1;
    do_reset();
    check("mid_wcases", 64'(win_cases),           64'd0);
    check("mid_last",   64'(last_window_correct), 64'd0);
    check("mid_total",  64'(total_cases),         64'd0);
    tick();
    tick();
    check("hold_high_valid", 64'(case_valid), 64'd0);
    bnd(10'h001, 64'h0);
    check("post_rst1", 64'(case_valid), 64'd0);
    bnd(10'h002, 64'h0);
    check("post_rst2", 64'(case_valid), 64'd0);
    bnd(10'h004, 64'h001);
    check("post_rst3", 64'(case_valid), 64'd1);

    // Fast toggle: boundary every 2 clks, each graded
    t0 = int'(total_cases);
    for (int i = 0; i < 12; i++) begin
      lbl = NOUT'(1) << $urandom_range(0, NOUT-1);
      bnd(lbl, {$urandom, $urandom});
    end
    check("fast_total_delta", 64'(int'(total_cases) - t0), 64'd12);

    // Random traffic with random cycle_clk phases and occasional resets
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 3) == 0) lbl = NOUT'($urandom);
      else lbl = NOUT'(1) << $urandom_range(0, NOUT-1);
      act = {$urandom, $urandom};
      // Half the time make the output match the label due for grading
      if ($urandom_range(0, 1) == 1 && m_q.size() >= DELAY)
        act[NOUT-1:0] = m_q[0];
      cycle_clk = 1'b0;
      repeat ($urandom_range(1, 3)) tick();
      cycle_clk = 1'b1;
      ans_tc = lbl;
      actL_alln = act;
      repeat ($urandom_range(1, 3)) tick();
      if ($urandom_range(0, 39) == 0) do_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
